// File: rtl/dispatch_queue.sv
`default_nettype none
// ============================================================================
//  Module      : dispatch_queue (with package dispatch_queue_pkg)
//  Description : Decode-to-dispatch instruction buffer. In-order circular
//                queue of decoded instructions that absorbs back-pressure
//                from dispatch, converts the decoder's inst_valid verdict
//                into an illegal-instruction flag (pop_ine) and supports a
//                single-cycle flush.
//  Ports       : clk, rst (async, active-high), flush
//                push_valid / push_inst_valid / push_data / push_ready
//                pop_valid / pop_data / pop_ine / pop_ready
//                count (current occupancy)
//  Options     : DISPATCH_QUEUE_BYPASS_EN - when defined, an empty queue
//                forwards the decoder input combinationally to dispatch.
//  Revision    : 1.0 - initial release
// ============================================================================

package dispatch_queue_pkg;

    typedef enum logic [4:0] {
        ALU_NOP = 5'd0,
        ALU_ADD = 5'd1,
        ALU_SUB = 5'd2,
        ALU_AND = 5'd3,
        ALU_OR  = 5'd4,
        ALU_XOR = 5'd5,
        ALU_SLL = 5'd6,
        ALU_SRL = 5'd7
    } alu_op_e;

    typedef struct packed {
        logic [31:0] pc;
        alu_op_e     aluop;
        logic [4:0]  rd;
        logic [4:0]  rj;
        logic [4:0]  rk;
        logic [31:0] imm;
    } id_dispatch_t;

endpackage

module dispatch_queue
    import dispatch_queue_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int CNT_W = $clog2(DEPTH) + 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               flush,
    input  logic               push_valid,
    input  logic               push_inst_valid,
    input  id_dispatch_t       push_data,
    output logic               push_ready,
    output logic               pop_valid,
    output id_dispatch_t       pop_data,
    output logic               pop_ine,
    input  logic               pop_ready,
    output logic [CNT_W-1:0]   count
);

    localparam int c_addr_w = $clog2(DEPTH);
    localparam int c_ptr_w  = c_addr_w + 1;

    // Pointers carry one extra wrap bit to tell full from empty.
    logic [c_ptr_w-1:0]  r_wptr;
    logic [c_ptr_w-1:0]  r_rptr;

    // Payload storage is never reset; only the pointers define validity.
    id_dispatch_t        r_mem_data [DEPTH];
    logic [DEPTH-1:0]    r_mem_ine;

    logic                w_empty;
    logic                w_full;
    logic                w_push;
    logic                w_pop;
    logic [c_ptr_w-1:0]  w_count;
    logic [c_addr_w-1:0] w_waddr;
    logic [c_addr_w-1:0] w_raddr;

    assign w_waddr = r_wptr[c_addr_w-1:0];
    assign w_raddr = r_rptr[c_addr_w-1:0];

    assign w_empty = (r_wptr == r_rptr);
    assign w_full  = (w_waddr == w_raddr) &&
                     (r_wptr[c_addr_w] != r_rptr[c_addr_w]);

    // Depends only on state, so dispatch back-pressure never reaches decode
    // combinationally; a full queue refuses even when it pops this cycle.
    assign push_ready = !w_full;

    assign w_count = r_wptr - r_rptr;
    assign count   = CNT_W'(w_count);

    // Only a buffered entry advances the read pointer; a bypassed
    // instruction never occupies a slot.
    assign w_pop = pop_ready && !w_empty;

`ifdef DISPATCH_QUEUE_BYPASS_EN
    logic w_bypass;

    // Flush kills the forwarded instruction together with the queue.
    assign w_bypass  = w_empty && push_valid && !flush;
    assign pop_valid = !w_empty || w_bypass;
    assign pop_data  = w_empty ? push_data        : r_mem_data[w_raddr];
    assign pop_ine   = w_empty ? ~push_inst_valid : r_mem_ine[w_raddr];

    // A forwarded instruction that dispatch takes right away is never stored.
    assign w_push = push_valid && push_ready && !(w_bypass && pop_ready);
`else
    assign pop_valid = !w_empty;
    assign pop_data  = r_mem_data[w_raddr];
    assign pop_ine   = r_mem_ine[w_raddr];
    assign w_push    = push_valid && push_ready;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wptr <= '0;
            r_rptr <= '0;
        end else if (flush) begin
            r_wptr <= '0;
            r_rptr <= '0;
        end else begin
            if (w_push) begin
                r_wptr <= r_wptr + c_ptr_w'(1);
            end
            if (w_pop) begin
                r_rptr <= r_rptr + c_ptr_w'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_push && !flush) begin
            r_mem_data[w_waddr] <= push_data;
            r_mem_ine[w_waddr]  <= ~push_inst_valid;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_dispatch_queue.sv
`default_nettype none
// ============================================================================
//  Module      : tb_dispatch_queue
//  Description : Self-checking bench for dispatch_queue. A queue-based model
//                predicts every output each cycle; directed scenarios add
//                hand-computed literal expectations; a random phase follows.
//                Honours DISPATCH_QUEUE_BYPASS_EN when defined.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_dispatch_queue;
    import dispatch_queue_pkg::*;

    localparam int DEPTH = 8;
    localparam int CNT_W = $clog2(DEPTH) + 1;
`ifdef DISPATCH_QUEUE_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic             clk = 1'b0;
    logic             rst;
    logic             flush;
    logic             push_valid;
    logic             push_inst_valid;
    id_dispatch_t     push_data;
    logic             push_ready;
    logic             pop_valid;
    id_dispatch_t     pop_data;
    logic             pop_ine;
    logic             pop_ready;
    logic [CNT_W-1:0] count;

    int n_checks = 0;
    int n_fail   = 0;

    dispatch_queue #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clk             (clk),
        .rst             (rst),
        .flush           (flush),
        .push_valid      (push_valid),
        .push_inst_valid (push_inst_valid),
        .push_data       (push_data),
        .push_ready      (push_ready),
        .pop_valid       (pop_valid),
        .pop_data        (pop_data),
        .pop_ine         (pop_ine),
        .pop_ready       (pop_ready),
        .count           (count)
    );

    always #5 clk = ~clk;

    // ---------------- reference model: plain FIFO of entries --------------
    typedef struct {
        id_dispatch_t d;
        logic         ine;
    } ent_t;

    ent_t mq[$];

    task automatic chk(input string name, input logic [127:0] act,
                       input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    always @(posedge rst) mq.delete();

    always @(posedge clk) begin
        if (!rst) begin
            if (flush) begin
                mq.delete();
            end else begin
                automatic bit full  = (mq.size() == DEPTH);
                automatic bit empty = (mq.size() == 0);
                automatic bit taken = BYP && empty && push_valid && pop_ready;
                if (!taken) begin
                    if (pop_ready && !empty) void'(mq.pop_front());
                    if (push_valid && !full) begin
                        ent_t e;
                        e.d   = push_data;
                        e.ine = !push_inst_valid;
                        mq.push_back(e);
                    end
                end
            end
        end
    end

    // Per-cycle comparison, mid-cycle and well away from the active edge.
    always @(negedge clk) begin
        if (!rst) begin
            automatic int sz = mq.size();
            automatic bit exp_pv = (sz > 0) || (BYP && push_valid && !flush);
            chk("push_ready", push_ready, sz != DEPTH);
            chk("count", count, sz);
            chk("pop_valid", pop_valid, exp_pv);
            if (exp_pv && pop_valid) begin
                chk("pop_data", pop_data, (sz > 0) ? mq[0].d : push_data);
                chk("pop_ine", pop_ine, (sz > 0) ? mq[0].ine : !push_inst_valid);
            end
        end
    end

    // ---------------- stimulus helpers ------------------------------------
    function automatic id_dispatch_t mk(input logic [31:0] pc, input logic iv);
        id_dispatch_t d;
        d.pc    = pc;
        d.aluop = iv ? alu_op_e'(5'($urandom_range(1, 7))) : ALU_NOP;
        d.rd    = 5'($urandom);
        d.rj    = 5'($urandom);
        d.rk    = 5'($urandom);
        d.imm   = $urandom;
        return d;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic pv, input logic iv, input logic [31:0] pc,
                         input logic pr, input logic fl);
        push_valid      = pv;
        push_inst_valid = iv;
        push_data       = mk(pc, iv);
        pop_ready       = pr;
        flush           = fl;
    endtask

    task automatic idle();
        push_valid = 1'b0;
        pop_ready  = 1'b0;
        flush      = 1'b0;
    endtask

    logic [31:0] pcs [3];
    logic        ivs [3];

    initial begin
        rst = 1'b1;
        drive(1'b0, 1'b1, 32'h0, 1'b0, 1'b0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        #1;
        chk("rst_count", count, 0);
        chk("rst_push_ready", push_ready, 1);
        chk("rst_pop_valid", pop_valid, 0);

        // In-order delivery of three entries.
        pcs[0] = 32'h1C000000; pcs[1] = 32'h1C000004; pcs[2] = 32'h1C000008;
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 1'b1, pcs[i], 1'b0, 1'b0);
            tick();
        end
        idle();
        #1;
        chk("three_count", count, 3);
        chk("three_push_ready", push_ready, 1);
        for (int i = 0; i < 3; i++) begin
            pop_ready = 1'b1;
            #1;
            chk("order_pop_valid", pop_valid, 1);
            chk("order_pc", pop_data.pc, pcs[i]);
            tick();
        end
        #1;
        chk("drained_pop_valid", pop_valid, 0);

        // Fill, then a refused push while popping, accepted next cycle.
        for (int i = 0; i < DEPTH; i++) begin
            drive(1'b1, 1'b1, 32'h100 + 32'(4 * i), 1'b0, 1'b0);
            tick();
        end
        idle();
        #1;
        chk("full_count", count, 8);
        chk("full_push_ready", push_ready, 0);
        drive(1'b1, 1'b1, 32'h120, 1'b1, 1'b0);
        #1;
        chk("full_pop_reject_ready", push_ready, 0);
        tick();
        chk("after_reject_count", count, 7);
        pop_ready = 1'b0;
        tick();
        chk("retry_count", count, 8);
        idle();
        pop_ready = 1'b1;
        repeat (DEPTH) tick();
        chk("drain8_count", count, 0);
        idle();

        // Steady streaming through several wrap-arounds.
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 1'b1, 32'h2000 + 32'(4 * i), 1'b0, 1'b0);
            tick();
        end
        for (int i = 3; i < 43; i++) begin
            drive(1'b1, 1'b1, 32'h2000 + 32'(4 * i), 1'b1, 1'b0);
            tick();
            if (i % 10 == 0) chk("stream_count", count, 3);
        end
        idle();
        pop_ready = 1'b1;
        repeat (4) tick();
        chk("stream_drain_count", count, 0);
        idle();

        // Unrecognised instruction between two valid ones.
        ivs[0] = 1'b1; ivs[1] = 1'b0; ivs[2] = 1'b1;
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, ivs[i], 32'h3000 + 32'(4 * i), 1'b0, 1'b0);
            tick();
        end
        idle();
        for (int i = 0; i < 3; i++) begin
            pop_ready = 1'b1;
            #1;
            chk("ine_flag", pop_ine, !ivs[i]);
            tick();
        end
        idle();

        // Flush with concurrent push and pop.
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, 1'b1, 32'h4000 + 32'(4 * i), 1'b0, 1'b0);
            tick();
        end
        drive(1'b1, 1'b1, 32'h4100, 1'b1, 1'b1);
        tick();
        idle();
        #1;
        chk("flush_count", count, 0);
        chk("flush_pop_valid", pop_valid, 0);

        // Asynchronous reset in the middle of a burst.
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 1'b1, 32'h5000 + 32'(4 * i), 1'b0, 1'b0);
            tick();
        end
        #2;
        push_valid = 1'b0;
        rst = 1'b1;
        #1;
        chk("async_rst_count", count, 0);
        chk("async_rst_pop_valid", pop_valid, 0);
        tick();
        rst = 1'b0;
        idle();
        tick();

        // Empty queue, push and pop presented together.
        drive(1'b1, 1'b1, 32'h0000ABC0, 1'b1, 1'b0);
        #1;
`ifdef DISPATCH_QUEUE_BYPASS_EN
        chk("bypass_pop_valid", pop_valid, 1);
        chk("bypass_pop_data", pop_data, push_data);
        tick();
        push_valid = 1'b0;
        #1;
        chk("bypass_count", count, 0);
        chk("bypass_after_pop_valid", pop_valid, 0);
`else
        chk("nobypass_pop_valid", pop_valid, 0);
        tick();
        push_valid = 1'b0;
        #1;
        chk("nobypass_late_pop_valid", pop_valid, 1);
        chk("nobypass_late_pc", pop_data.pc, 32'h0000ABC0);
        tick();
        chk("nobypass_count", count, 0);
`endif
        idle();
        tick();

        // Random traffic with phases biased toward filling and draining.
        for (int i = 0; i < 3000; i++) begin
            automatic int phase = (i / 200) % 3;
            automatic int pv_pct = (phase == 0) ? 85 : (phase == 1) ? 30 : 60;
            automatic int pr_pct = (phase == 0) ? 30 : (phase == 1) ? 85 : 60;
            automatic bit hold = push_valid && (mq.size() == DEPTH);
            if (!hold) begin
                automatic logic iv = ($urandom_range(0, 99) < 80);
                push_valid      = ($urandom_range(0, 99) < pv_pct);
                push_inst_valid = iv;
                push_data       = mk($urandom, iv);
            end
            pop_ready = ($urandom_range(0, 99) < pr_pct);
            flush     = ($urandom_range(0, 99) < 2);
            tick();
        end
        idle();
        repeat (3) tick();

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/dispatch_queue.md
# dispatch_queue

Decode-to-dispatch instruction buffer that receives decoded instructions (`id_dispatch_t`) from the instruction decoders and hands them in order to the dispatch stage. It absorbs back-pressure from dispatch and turns the decoder's per-instruction `inst_valid` verdict into an explicit illegal-instruction flag. It supports a full pipeline flush on branch mispredict or exception.

## Interface

Parameters:
- `DEPTH`, 8: number of entries. Must be a power of two, ≥ 2.
- `CNT_W`, `$clog2(DEPTH)+1`: width of the occupancy count.

Ports:
- `clk`, input, 1: single clock.
- `rst`, input, 1: reset, asynchronous, active-high.
- `flush`, input, 1: discards all entries at the next edge.
- `push_valid`, input, 1: decoder presents an instruction.
- `push_inst_valid`, input, 1: decoder `inst_valid` output for that instruction.
- `push_data`, input, `id_dispatch_t`: decoded instruction.
- `push_ready`, output, 1: queue accepts this cycle.
- `pop_valid`, output, 1: head entry is valid.
- `pop_data`, output, `id_dispatch_t`: head entry.
- `pop_ine`, output, 1: head entry was not recognised by the decoder (`push_inst_valid` was 0).
- `pop_ready`, input, 1: dispatch consumes the head this cycle.
- `count`, output, `CNT_W`: current occupancy.

## Operation

- Circular buffer with a write pointer and a read pointer, each `$clog2(DEPTH)+1` bits. The extra MSB is the wrap bit.
  - Empty: pointers are equal.
  - Full: low bits are equal and the MSBs differ.
- Push fires when `push_valid && push_ready`.
  - Stores `push_data` and `~push_inst_valid` at the write pointer, then increments the write pointer.
- Pop fires when `pop_valid && pop_ready`.
  - Increments the read pointer.
- `push_ready = !full`. It does not depend on `pop_ready`, so there is no combinational path from dispatch to decode. A full queue rejects a push even in a cycle where it pops.
- Push and pop in the same cycle: both pointers advance and `count` is unchanged.
- `count = wptr - rptr`, using modulo `2^CNT_W` arithmetic.
- `flush` has priority over push and pop.
  - On the next edge both pointers are set to 0.
  - A push presented in the flush cycle is dropped.
  - `push_ready` keeps its normal value during flush.
- Pointers wrap naturally. Behaviour is identical after any number of wrap-arounds.
- `pop_data` and `pop_ine` are don't-care whenever `pop_valid=0`. The bench must not check them then.
- Storage needs no reset. Only the pointers are reset.

## Timing

- Reset values: both pointers 0, `push_ready=1`, `pop_valid=0`, `count=0`. `pop_data`/`pop_ine` are unspecified.
- Asserting `rst` mid-operation empties the queue immediately, without waiting for a clock edge.
- With bypass disabled, latency from push to visibility is 1 cycle: an entry pushed at edge N drives `pop_valid` after edge N.
- `pop_valid`, `push_ready` and `count` are driven from registers only, except in bypass mode (see Configuration).
- Handshake rules:
  - Once `pop_valid` is asserted, the head stays stable until it is popped or flushed.
  - The decoder must hold `push_data` stable while `push_valid && !push_ready`.

## Configuration

- `DISPATCH_QUEUE_BYPASS_EN` defined:
  - When the queue is empty, `pop_valid = push_valid`, `pop_data = push_data` and `pop_ine = ~push_inst_valid`, all combinationally. This gives zero-cycle latency.
  - If `pop_ready` is also 1 in that cycle, the instruction is consumed and neither pointer moves.
  - Otherwise the instruction is written normally.
  - Bypass is suppressed while `flush=1`.
- `DISPATCH_QUEUE_BYPASS_EN` undefined:
  - All outputs come from the buffer and the minimum latency is 1 cycle.

## Test plan

- Reset, then push 3 entries with `pc`=0x1C000000/04/08 while `pop_ready=0` → `count=3`, `push_ready=1`. Then set `pop_ready=1` → entries pop in order over 3 cycles, then `pop_valid=0`.
- Fill with `DEPTH`=8 pushes → `count=8`, `push_ready=0`. Ninth push with `pop_ready=1` → rejected that cycle, `count=7`, accepted the following cycle.
- Continuous push and pop for 40 cycles with a `pc` increment of 4 → no loss or duplication across 5 wrap-arounds, `count` stays constant.
- Push with `push_inst_valid=0` (opcode not matched, `aluop=ALU_NOP`) → the entry pops with `pop_ine=1`. The neighbouring valid entries pop with `pop_ine=0`.
- 5 entries queued, then `flush=1` together with a push and a pop → next cycle `count=0`, `pop_valid=0`, the pushed entry is absent. Assert `rst` mid-burst → `count=0` immediately.
- Bypass build: empty queue, `push_valid=1`, `pop_ready=1` → `pop_valid=1` in the same cycle with `pop_data==push_data`, `count` stays 0. Non-bypass build with the same stimulus → `pop_valid` appears 1 cycle later.
